// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Owns the SDRAM command/address/bank pins. Before init completes the pins
//   carry the init block's command and address. Afterwards the bus is granted
//   to one of three requesters (auto-refresh > write > read). A one-cycle
//   enable pulse starts the granted requester, and its command, address and
//   bank are muxed onto the pins until its done pulse. Single-cycle refresh
//   requests are latched. Two sticky flags record a refresh request that
//   collided with one already pending, and a grant that never completed.
//
// Ports
//   sdram_clk, rst_n          : clock, async active-low reset
//   init_done/init_cmd/addr   : init block handoff (level) and its pin values
//   aref_req/done/cmd/addr    : refresh requester, aref_en grant pulse
//   wr_req/done/cmd/addr/ba   : write requester, wr_en grant pulse
//   rd_req/done/cmd/addr/ba   : read requester, rd_en grant pulse
//   sdram_cmd/addr/ba         : SDRAM pins, {CS_n,RAS_n,CAS_n,WE_n} command
//   aref_miss, err_timeout    : sticky error flags, cleared only by rst_n
//
// TIMEOUT must be at least 16.
module sdram_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int BA_BITS   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 aref_req,
    input  logic                 aref_done,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    output logic                 aref_en,
    input  logic                 wr_req,
    input  logic                 wr_done,
    input  logic [3:0]           wr_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    output logic                 wr_en,
    input  logic                 rd_req,
    input  logic                 rd_done,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   rd_ba,
    output logic                 rd_en,
    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba,
    output logic                 aref_miss,
    output logic                 err_timeout
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       CMD_NOP  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AREF  = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             aref_pending;
    logic             done_match;
    logic             tmo_hit;

    // Done of the currently granted requester. A done for any other
    // requester, or one arriving in IDLE, is ignored.
    always_comb begin
        done_match = 1'b0;
        case (state)
            ST_AREF:  done_match = aref_done;
            ST_WRITE: done_match = wr_done;
            ST_READ:  done_match = rd_done;
            default:  done_match = 1'b0;
        endcase
        // A done on the limit cycle wins: that is a normal completion.
        tmo_hit = (state != ST_IDLE) && !done_match && (tmo_cnt == TMO_LAST);
    end

    // State register
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. Losing init_done aborts whatever is granted.
    always_comb begin
        state_nxt = state;
        if (!init_done) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aref_pending || aref_req) state_nxt = ST_AREF;
                    else if (wr_req)              state_nxt = ST_WRITE;
                    else if (rd_req)              state_nxt = ST_READ;
                end
                default: begin
                    if (done_match || tmo_hit) state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Pin mux, straight from the state register so the granted requester
    // drives the pins in the same cycle its enable is high.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        case (state)
            ST_IDLE: begin
                if (!init_done) begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

    // Grant pulses, timeout counter, refresh latch and sticky flags.
    // Every grant starts from IDLE, so a pulse fires only on the IDLE exit.
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            aref_en      <= 1'b0;
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            tmo_cnt      <= '0;
            aref_pending <= 1'b0;
            aref_miss    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            aref_en <= (state == ST_IDLE) && (state_nxt == ST_AREF);
            wr_en   <= (state == ST_IDLE) && (state_nxt == ST_WRITE);
            rd_en   <= (state == ST_IDLE) && (state_nxt == ST_READ);

            if ((state == ST_IDLE) || (state_nxt != state)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            // A fresh request outranks the clear from the current grant.
            if (!init_done) begin
                aref_pending <= 1'b0;
            end else if (aref_req) begin
                aref_pending <= 1'b1;
            end else if (aref_en) begin
                aref_pending <= 1'b0;
            end

            if (init_done && aref_req && aref_pending && !aref_en) begin
                aref_miss <= 1'b1;
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init passthrough, refresh grant,
// priority ordering, refresh latching and miss flag, timeout boundary,
// timeout error, asynchronous reset and init_done loss.
module tb_sdram_arbiter;

    localparam int ADDR_BITS = 12;
    localparam int BA_BITS   = 2;
    localparam int TIMEOUT   = 64;

    localparam logic [3:0]           C_INIT = 4'b0010;
    localparam logic [3:0]           C_AREF = 4'b0001;
    localparam logic [3:0]           C_WR   = 4'b0100;
    localparam logic [3:0]           C_RD   = 4'b0101;
    localparam logic [3:0]           C_NOP  = 4'b0111;
    localparam logic [ADDR_BITS-1:0] A_INIT = 12'h0A5;
    localparam logic [ADDR_BITS-1:0] A_AREF = 12'h400;
    localparam logic [ADDR_BITS-1:0] A_WR   = 12'h123;
    localparam logic [ADDR_BITS-1:0] A_RD   = 12'h456;
    localparam logic [BA_BITS-1:0]   B_WR   = 2'd2;
    localparam logic [BA_BITS-1:0]   B_RD   = 2'd1;

    logic                 sdram_clk;
    logic                 rst_n;
    logic                 init_done;
    logic [3:0]           init_cmd;
    logic [ADDR_BITS-1:0] init_addr;
    logic                 aref_req;
    logic                 aref_done;
    logic [3:0]           aref_cmd;
    logic [ADDR_BITS-1:0] aref_addr;
    logic                 aref_en;
    logic                 wr_req;
    logic                 wr_done;
    logic [3:0]           wr_cmd;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [BA_BITS-1:0]   wr_ba;
    logic                 wr_en;
    logic                 rd_req;
    logic                 rd_done;
    logic [3:0]           rd_cmd;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [BA_BITS-1:0]   rd_ba;
    logic                 rd_en;
    logic [3:0]           sdram_cmd;
    logic [ADDR_BITS-1:0] sdram_addr;
    logic [BA_BITS-1:0]   sdram_ba;
    logic                 aref_miss;
    logic                 err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    sdram_arbiter #(
        .ADDR_BITS(ADDR_BITS),
        .BA_BITS  (BA_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .sdram_clk  (sdram_clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .init_cmd   (init_cmd),
        .init_addr  (init_addr),
        .aref_req   (aref_req),
        .aref_done  (aref_done),
        .aref_cmd   (aref_cmd),
        .aref_addr  (aref_addr),
        .aref_en    (aref_en),
        .wr_req     (wr_req),
        .wr_done    (wr_done),
        .wr_cmd     (wr_cmd),
        .wr_addr    (wr_addr),
        .wr_ba      (wr_ba),
        .wr_en      (wr_en),
        .rd_req     (rd_req),
        .rd_done    (rd_done),
        .rd_cmd     (rd_cmd),
        .rd_addr    (rd_addr),
        .rd_ba      (rd_ba),
        .rd_en      (rd_en),
        .sdram_cmd  (sdram_cmd),
        .sdram_addr (sdram_addr),
        .sdram_ba   (sdram_ba),
        .aref_miss  (aref_miss),
        .err_timeout(err_timeout)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] cmd,
                           input logic [ADDR_BITS-1:0] addr, input logic [BA_BITS-1:0] ba);
        chk({tag, ".cmd"},  32'(sdram_cmd),  32'(cmd));
        chk({tag, ".addr"}, 32'(sdram_addr), 32'(addr));
        chk({tag, ".ba"},   32'(sdram_ba),   32'(ba));
    endtask

    task automatic chk_en(input string tag, input logic a, input logic w, input logic r);
        chk({tag, ".en"}, 32'({aref_en, wr_en, rd_en}), 32'({a, w, r}));
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick(input int n);
        repeat (n) @(posedge sdram_clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        init_done = 1'b0;
        init_cmd  = C_INIT;  init_addr = A_INIT;
        aref_cmd  = C_AREF;  aref_addr = A_AREF;
        wr_cmd    = C_WR;    wr_addr   = A_WR;  wr_ba = B_WR;
        rd_cmd    = C_RD;    rd_addr   = A_RD;  rd_ba = B_RD;
        aref_req  = 1'b0;  aref_done = 1'b0;
        wr_req    = 1'b0;  wr_done   = 1'b0;
        rd_req    = 1'b0;  rd_done   = 1'b0;

        // Reset state
        #3;
        chk_bus("rst", C_INIT, A_INIT, '0);
        chk_en("rst", 0, 0, 0);
        chk("rst.miss", 32'(aref_miss), 32'd0);
        chk("rst.tmo", 32'(err_timeout), 32'd0);
        tick(2);
        rst_n = 1'b1;

        // Before init: init passthrough, write request ignored
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_bus("preinit", C_INIT, A_INIT, '0);
            chk_en("preinit", 0, 0, 0);
        end
        wr_req = 1'b0;

        // Single refresh
        init_done = 1'b1;
        tick(1);
        chk_bus("idle", C_NOP, '0, '0);
        aref_req = 1'b1;
        tick(1);
        aref_req = 1'b0;
        chk_en("aref.grant", 1, 0, 0);
        chk_bus("aref.grant", C_AREF, A_AREF, '0);
        for (int i = 0; i < 11; i++) begin
            tick(1);
            chk_en("aref.hold", 0, 0, 0);
            chk("aref.hold.cmd", 32'(sdram_cmd), 32'(C_AREF));
        end
        aref_done = 1'b1;
        tick(1);
        aref_done = 1'b0;
        chk_bus("aref.end", C_NOP, '0, '0);
        tick(2);
        chk_bus("aref.nopend", C_NOP, '0, '0);
        chk_en("aref.nopend", 0, 0, 0);

        // Priority: refresh, then write, then read
        wr_req = 1'b1; rd_req = 1'b1; aref_req = 1'b1;
        tick(1);
        aref_req = 1'b0;
        chk_en("prio.aref", 1, 0, 0);
        chk("prio.aref.cmd", 32'(sdram_cmd), 32'(C_AREF));
        tick(2);
        aref_done = 1'b1;
        tick(1);
        aref_done = 1'b0;
        chk_bus("prio.gap1", C_NOP, '0, '0);
        chk_en("prio.gap1", 0, 0, 0);
        tick(1);
        chk_en("prio.wr", 0, 1, 0);
        chk_bus("prio.wr", C_WR, A_WR, B_WR);
        wr_req = 1'b0;
        tick(2);
        chk_bus("prio.wrhold", C_WR, A_WR, B_WR);
        chk_en("prio.wrhold", 0, 0, 0);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        chk_bus("prio.gap2", C_NOP, '0, '0);
        tick(1);
        chk_en("prio.rd", 0, 0, 1);
        chk_bus("prio.rd", C_RD, A_RD, B_RD);
        rd_req = 1'b0;
        tick(1);
        rd_done = 1'b1;
        tick(1);
        rd_done = 1'b0;
        chk_bus("prio.end", C_NOP, '0, '0);

        // Refresh requested during write is latched; a second one before
        // the grant sets the sticky miss flag
        wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        chk_en("latch.wr", 0, 1, 0);
        aref_req = 1'b1;
        tick(1);
        aref_req = 1'b0;
        chk_bus("latch.wrhold", C_WR, A_WR, B_WR);
        tick(6);
        chk("latch.nomiss", 32'(aref_miss), 32'd0);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        chk_bus("latch.gap", C_NOP, '0, '0);
        chk_en("latch.gap", 0, 0, 0);
        aref_req = 1'b1;
        tick(1);
        aref_req = 1'b0;
        chk_en("latch.aref", 1, 0, 0);
        chk("latch.miss", 32'(aref_miss), 32'd1);
        aref_done = 1'b1;
        tick(1);
        aref_done = 1'b0;
        tick(2);
        chk_bus("latch.idle", C_NOP, '0, '0);
        chk("latch.miss.sticky", 32'(aref_miss), 32'd1);

        // Done on the timeout-limit cycle is a normal completion
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        chk_en("lim.rd", 0, 0, 1);
        tick(62);
        chk("lim.rd63", 32'(sdram_cmd), 32'(C_RD));
        tick(1);
        chk("lim.rd64", 32'(sdram_cmd), 32'(C_RD));
        rd_done = 1'b1;
        tick(1);
        rd_done = 1'b0;
        chk_bus("lim.end", C_NOP, '0, '0);
        chk("lim.noerr", 32'(err_timeout), 32'd0);

        // Hung write times out, pending read then granted
        wr_req = 1'b1; rd_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        chk_en("tmo.wr", 0, 1, 0);
        tick(62);
        chk("tmo.wr63", 32'(sdram_cmd), 32'(C_WR));
        chk("tmo.noerr", 32'(err_timeout), 32'd0);
        tick(1);
        chk("tmo.wr64", 32'(sdram_cmd), 32'(C_WR));
        tick(1);
        chk_bus("tmo.idle", C_NOP, '0, '0);
        chk("tmo.err", 32'(err_timeout), 32'd1);
        tick(1);
        chk_en("tmo.rd", 0, 0, 1);
        chk_bus("tmo.rd", C_RD, A_RD, B_RD);
        rd_req = 1'b0;

        // Asynchronous reset in the middle of a read
        tick(2);
        chk("ares.pre", 32'(sdram_cmd), 32'(C_RD));
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("ares.async", C_NOP, '0, '0);
        chk_en("ares.async", 0, 0, 0);
        chk("ares.miss", 32'(aref_miss), 32'd0);
        chk("ares.tmo", 32'(err_timeout), 32'd0);
        init_done = 1'b0;
        #1;
        chk_bus("ares.init", C_INIT, A_INIT, '0);
        init_done = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk_bus("ares.post", C_NOP, '0, '0);
        chk_en("ares.post", 0, 0, 0);

        // init_done dropping aborts a grant and blocks new ones
        wr_req = 1'b1;
        tick(1);
        chk_en("drop.wr", 0, 1, 0);
        init_done = 1'b0;
        tick(1);
        chk_bus("drop.idle", C_INIT, A_INIT, '0);
        chk_en("drop.idle", 0, 0, 0);
        tick(1);
        chk_en("drop.hold", 0, 0, 0);
        init_done = 1'b1;
        tick(1);
        chk_en("drop.regrant", 0, 1, 0);
        wr_req  = 1'b0;
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        chk_bus("drop.end", C_NOP, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
